apb_pwm_mc: RTL and testbench
=============================

# apb_pwm_mc

Multi-channel APB PWM generator. Successor to the single-channel APB PWM: it adds a channel count parameter, a configurable counter width, per-channel polarity and center-aligned mode, and shadowed PERIOD/COMP registers that take effect only at period boundaries, so duty-cycle updates never glitch. It sits on the peripheral APB bus beside the other timers and drives NUM_CH PWM pins plus an optional interrupt line.

## Interface
- NUM_CH, 4, number of channels, 1..8
- CNT_W, 16, counter/PERIOD/COMP width, 2..32. Register bits above CNT_W read 0 and ignore writes.
- apb_pclk  in  1  clock
- apb_prstn  in  1  reset. Asynchronous, active-low, clears every flop.
- apb_psel, apb_penable, apb_pwrite  in  1 each  APB control
- apb_paddr  in  32  address. Only [7:0] is decoded.
- apb_pwdata  in  32  write data
- apb_prdata  out  32  read data
- pwm_out  out  NUM_CH  PWM outputs, bit n = channel n
- pwm_irq  out  1  level interrupt (PWM_MC_IRQ_EN only, else tied 0)

## Operation
- APB access:
  - Write strobe is psel&penable&pwrite; read strobe is psel&penable&~pwrite.
  - No wait states, no error response.
  - apb_prdata is combinational. It is 0 outside a read strobe and for unmapped addresses.
- Per-channel map at offset n*0x10, n < NUM_CH:
  - +0x0 PERIOD (RW, shadow)
  - +0x4 COMP (RW, shadow)
  - +0x8 CTRL (RW): bit0 EN, bit1 POL, bit2 CENTER
  - +0xC CNT (RO, live counter)
- Global registers:
  - 0xF0 INT_STAT: bit n set at channel n period end; write-1-to-clear.
  - 0xF4 INT_EN: bit n enables that channel's interrupt.
- Reads of PERIOD/COMP return the shadow value.
- Active registers (act_p, act_c) load from shadow at each period boundary, and on every cycle while EN=0. CTRL bits take effect immediately.
- Edge mode (CENTER=0):
  - cnt counts 0..act_p-1, then wraps to 0.
  - Boundary is the cycle cnt==act_p-1.
- Center mode (CENTER=1):
  - cnt counts up 0..act_p, then down act_p-1..1, then restarts at 0. Period is 2*act_p cycles.
  - Boundary is the cycle cnt==1 while counting down.
  - For act_p==1 the count is 0,1,0,1 and the boundary is at cnt==1.
  - The direction flag resets to up.
- Raw output is act = (cnt < act_c). This gives act_c=0 → 0%, and act_c ≥ act_p → 100% (center mode: high except at cnt==act_p when act_c==act_p).
- pwm_out[n] is registered: (EN && act_p!=0) ? act^POL : POL.
- act_p==0 while EN=1: cnt holds 0, output idles at POL, no boundary events.
- EN=0: cnt is held at 0 and the direction flag at up.
- Writing EN 0→1 starts the count at 0 with freshly loaded active values.
- A CTRL write toggling CENTER mid-period restarts cnt at 0, counting up.

## Timing
- Reset values:
  - All registers 0, cnt 0.
  - pwm_out all 0; pwm_irq 0.
- A register write at access cycle T is visible to the core at T+1.
- pwm_out lags cnt by one cycle. pwm_out[n] at T+1 reflects cnt at T.
- After an enabling write at T: cnt=0 at T+1, first pwm_out edge at T+2.
- Shadow write plus boundary in the same cycle: the active registers load the old shadow value; the new value applies at the next boundary.
- INT_STAT set and W1C of the same bit in the same cycle: set wins.
- Reset asserted mid-period forces all outputs low immediately (asynchronous), including channels with POL=1.

## Configuration
- PWM_MC_IRQ_EN defined:
  - INT_STAT and INT_EN exist.
  - pwm_irq is registered: |(INT_STAT & INT_EN), asserting one cycle after the status bit sets.
- Undefined:
  - No interrupt flops.
  - 0xF0/0xF4 read 0 and ignore writes; pwm_irq is constant 0.
- The PWM datapath is identical either way.

## Test plan
- Reset, then read all registers → all 0; pwm_out=0.
- Ch0: PERIOD=10, COMP=3, CTRL=1 → pwm_out[0] high 3 / low 7 cycles, repeating every 10; CNT reads 0..9.
- Ch1 edge mode with PERIOD=8, COMP=2, write COMP=6 mid-period → duty stays 2/8 until the boundary, then 6/8 with no runt pulse.
- Ch2: PERIOD=4, COMP=2, CTRL=0b111 (EN, POL, CENTER) → period 8 cycles; cnt 0,1,2,3,4,3,2,1; pwm_out low for cnt 0,1 and high otherwise (inverted polarity).
- Boundaries: COMP=0 → constant POL; COMP=PERIOD=5 edge → constant high; PERIOD=0 with EN → idle; EN cleared mid-period → CNT=0 next cycle.
- With PWM_MC_IRQ_EN: INT_EN=1, ch0 PERIOD=5 → INT_STAT[0] sets at cnt==4, pwm_irq high the next cycle; writing 1 to 0xF0 clears it. Apply reset mid-period → pwm_out and pwm_irq drop to 0 immediately.

Source files
------------

// File: rtl/apb_pwm_mc.sv
// ---------------------------------------------------------------------------
// apb_pwm_mc - multi-channel APB PWM generator
//
// Each channel has a free-running counter. PERIOD and COMP are shadow
// registers. The counter uses active copies of them, and those copies are
// reloaded only at a period boundary (or on every cycle while the channel
// is disabled), so duty updates never produce runt pulses. Each channel
// runs edge-aligned (saw-tooth) or center-aligned (triangle).
//
// Optional build macro: PWM_MC_IRQ_EN adds INT_STAT/INT_EN and a registered
// interrupt. Without the macro, 0xF0/0xF4 read 0 and pwm_irq is tied 0.
//
// Parameters:
//   NUM_CH       number of channels (1..8)
//   CNT_W        counter / PERIOD / COMP width (2..32)
// Ports:
//   apb_pclk     clock
//   apb_prstn    asynchronous active-low reset
//   apb_psel, apb_penable, apb_pwrite, apb_paddr[31:0], apb_pwdata[31:0]
//                APB slave inputs (only paddr[7:0] is decoded)
//   apb_prdata   combinational read data, 0 outside a read strobe
//   pwm_out      registered PWM outputs, bit n = channel n
//   pwm_irq      level interrupt (0 unless PWM_MC_IRQ_EN is defined)
//
// Register map (channel n at n*0x10):
//   +0x0 PERIOD (shadow)  +0x4 COMP (shadow)
//   +0x8 CTRL {CENTER, POL, EN}  +0xC CNT (read-only live counter)
//   0xF0 INT_STAT (W1C)  0xF4 INT_EN
// ---------------------------------------------------------------------------
module apb_pwm_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              apb_pclk,
  input  logic              apb_prstn,
  input  logic              apb_psel,
  input  logic              apb_penable,
  input  logic              apb_pwrite,
  input  logic [31:0]       apb_paddr,
  input  logic [31:0]       apb_pwdata,
  output logic [31:0]       apb_prdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              pwm_irq
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  // APB handshake: the slave never stalls (PREADY is implicitly 1). An access
  // completes in the single cycle where psel & penable are both high; pwrite
  // in that cycle selects a write (pwdata captured at the clock edge) or a
  // read (prdata driven combinationally in that same cycle).
  logic       w_wr;
  logic       w_rd;
  logic [7:0] w_addr;

  assign w_wr   = apb_psel & apb_penable & apb_pwrite;
  assign w_rd   = apb_psel & apb_penable & ~apb_pwrite;
  assign w_addr = apb_paddr[7:0];

  logic [NUM_CH-1:0]       w_bnd;     // per-channel period-boundary pulse
  logic [NUM_CH-1:0][31:0] w_rd_ch;   // per-channel read contribution
  logic [31:0]             w_rd_glb;  // global register read contribution
  logic [31:0]             w_rd_mux;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [CNT_W-1:0] r_shd_p;
    logic [CNT_W-1:0] r_shd_c;
    logic [CNT_W-1:0] r_act_p;
    logic [CNT_W-1:0] r_act_c;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_ctrl;
    dir_t             r_dir;
    logic             r_pwm;

    logic             w_sel;
    logic             w_wr_p;
    logic             w_wr_c;
    logic             w_wr_ctrl;
    logic             w_en;
    logic             w_pol;
    logic             w_ctr;
    logic             w_ctr_flip;
    logic [CNT_W-1:0] w_cnt_nxt;
    dir_t             w_dir_nxt;
    logic             w_load;
    logic             w_bnd_ch;
    logic [31:0]      w_rd_loc;

    assign w_sel      = (w_addr[7:4] == 4'(n)) && (w_addr[1:0] == 2'b00);
    assign w_wr_p     = w_wr & w_sel & (w_addr[3:2] == 2'd0);
    assign w_wr_c     = w_wr & w_sel & (w_addr[3:2] == 2'd1);
    assign w_wr_ctrl  = w_wr & w_sel & (w_addr[3:2] == 2'd2);
    assign w_en       = r_ctrl[0];
    assign w_pol      = r_ctrl[1];
    assign w_ctr      = r_ctrl[2];
    // Switching between edge and center mode mid-period restarts the count.
    assign w_ctr_flip = w_wr_ctrl & (apb_pwdata[2] != w_ctr);

    // Counter / direction next-state
    always_comb begin
      w_cnt_nxt = r_cnt;
      w_dir_nxt = r_dir;
      w_load    = 1'b0;
      w_bnd_ch  = 1'b0;
      if (!w_en) begin
        // Disabled: hold at 0 and keep the active copies tracking the shadows
        // so that enabling starts with fresh values.
        w_cnt_nxt = '0;
        w_dir_nxt = DIR_UP;
        w_load    = 1'b1;
      end else if (r_act_p == '0) begin
        w_cnt_nxt = '0;
        w_dir_nxt = DIR_UP;
      end else if (!w_ctr) begin
        w_dir_nxt = DIR_UP;
        if (r_cnt >= r_act_p - C_ONE) begin
          w_cnt_nxt = '0;
          w_load    = 1'b1;
          w_bnd_ch  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end else if (r_dir == DIR_UP) begin
        if (r_cnt >= r_act_p) begin
          if (r_act_p == C_ONE) begin
            // Degenerate triangle 0,1,0,1: the peak is also the boundary.
            w_cnt_nxt = '0;
            w_load    = 1'b1;
            w_bnd_ch  = 1'b1;
          end else begin
            w_cnt_nxt = r_act_p - C_ONE;
            w_dir_nxt = DIR_DOWN;
          end
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end else begin
        if (r_cnt <= C_ONE) begin
          w_cnt_nxt = '0;
          w_dir_nxt = DIR_UP;
          w_load    = 1'b1;
          w_bnd_ch  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      if (w_ctr_flip) begin
        w_cnt_nxt = '0;
        w_dir_nxt = DIR_UP;
      end
    end

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
      if (!apb_prstn) begin
        r_shd_p <= '0;
        r_shd_c <= '0;
        r_act_p <= '0;
        r_act_c <= '0;
        r_cnt   <= '0;
        r_ctrl  <= '0;
        r_dir   <= DIR_UP;
        r_pwm   <= 1'b0;
      end else begin
        if (w_wr_p)    r_shd_p <= apb_pwdata[CNT_W-1:0];
        if (w_wr_c)    r_shd_c <= apb_pwdata[CNT_W-1:0];
        if (w_wr_ctrl) r_ctrl  <= apb_pwdata[2:0];
        // Loads use the pre-write shadow, so a write landing on a boundary
        // cycle only takes effect at the following boundary.
        if (w_load) begin
          r_act_p <= r_shd_p;
          r_act_c <= r_shd_c;
        end
        r_cnt <= w_cnt_nxt;
        r_dir <= w_dir_nxt;
        r_pwm <= (w_en && (r_act_p != '0)) ? ((r_cnt < r_act_c) ^ w_pol) : w_pol;
      end
    end

    always_comb begin
      w_rd_loc = '0;
      if (w_sel) begin
        case (w_addr[3:2])
          2'd0:    w_rd_loc[CNT_W-1:0] = r_shd_p;
          2'd1:    w_rd_loc[CNT_W-1:0] = r_shd_c;
          2'd2:    w_rd_loc[2:0]       = r_ctrl;
          default: w_rd_loc[CNT_W-1:0] = r_cnt;
        endcase
      end
    end

    assign w_bnd[n]   = w_bnd_ch;
    assign w_rd_ch[n] = w_rd_loc;
    assign pwm_out[n] = r_pwm;
  end

`ifdef PWM_MC_IRQ_EN
  logic [NUM_CH-1:0] r_int_stat;
  logic [NUM_CH-1:0] r_int_en;
  logic              r_irq;
  logic              w_wr_stat;
  logic              w_wr_ien;

  assign w_wr_stat = w_wr & (w_addr == 8'hF0);
  assign w_wr_ien  = w_wr & (w_addr == 8'hF4);

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      r_int_stat <= '0;
      r_int_en   <= '0;
      r_irq      <= 1'b0;
    end else begin
      // OR-ing the new events after the clear makes a same-cycle set win.
      r_int_stat <= (r_int_stat & ~(w_wr_stat ? apb_pwdata[NUM_CH-1:0] : '0)) | w_bnd;
      if (w_wr_ien) r_int_en <= apb_pwdata[NUM_CH-1:0];
      r_irq <= |(r_int_stat & r_int_en);
    end
  end

  always_comb begin
    w_rd_glb = '0;
    if (w_addr == 8'hF0) w_rd_glb[NUM_CH-1:0] = r_int_stat;
    if (w_addr == 8'hF4) w_rd_glb[NUM_CH-1:0] = r_int_en;
  end

  assign pwm_irq = r_irq;
`else
  assign w_rd_glb = '0;
  assign pwm_irq  = 1'b0;
`endif

  always_comb begin
    w_rd_mux = w_rd_glb;
    for (int i = 0; i < NUM_CH; i++) w_rd_mux = w_rd_mux | w_rd_ch[i];
  end

  assign apb_prdata = w_rd ? w_rd_mux : 32'h0;

  // Deliberately ignored inputs/bits gathered in one place.
  logic w_unused;
  assign w_unused = &{1'b0, apb_paddr[31:8], apb_pwdata, w_bnd};

endmodule

// File: tb/tb_apb_pwm_mc.sv
// ---------------------------------------------------------------------------
// tb_apb_pwm_mc - self-checking bench for apb_pwm_mc (NUM_CH=4, CNT_W=16).
// The reference model tracks each channel as a phase index within its
// period and derives the counter value from it arithmetically.
// ---------------------------------------------------------------------------
module tb_apb_pwm_mc;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int MASK   = (1 << CNT_W) - 1;
`ifdef PWM_MC_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              psel = 1'b0;
  logic              pen = 1'b0;
  logic              pwrite = 1'b0;
  logic [31:0]       paddr = '0;
  logic [31:0]       pwdata = '0;
  logic [31:0]       prdata;
  logic [NUM_CH-1:0] pwm;
  logic              irq;

  apb_pwm_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .apb_pclk   (clk),
    .apb_prstn  (rst_n),
    .apb_psel   (psel),
    .apb_penable(pen),
    .apb_pwrite (pwrite),
    .apb_paddr  (paddr),
    .apb_pwdata (pwdata),
    .apb_prdata (prdata),
    .pwm_out    (pwm),
    .pwm_irq    (irq)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  int                m_sp[NUM_CH];
  int                m_sc[NUM_CH];
  int                m_ctrl[NUM_CH];
  int                m_ap[NUM_CH];
  int                m_ac[NUM_CH];
  int                m_k[NUM_CH];   // position within the current period
  logic [NUM_CH-1:0] m_pwm;
  logic [NUM_CH-1:0] m_stat;
  logic [NUM_CH-1:0] m_ien;
  logic              m_irq;

  task automatic m_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      m_sp[n] = 0; m_sc[n] = 0; m_ctrl[n] = 0;
      m_ap[n] = 0; m_ac[n] = 0; m_k[n] = 0;
    end
    m_pwm = '0; m_stat = '0; m_ien = '0; m_irq = 1'b0;
  endtask

  // Edge mode: counter equals phase. Center mode: phase 0..P climbs, then the
  // counter mirrors back down as 2P-phase.
  function automatic int m_cnt(input int n);
    if (((m_ctrl[n] >> 2) & 1) == 1 && m_k[n] > m_ap[n]) return 2 * m_ap[n] - m_k[n];
    return m_k[n];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int ch;
    ch = int'(a[7:4]);
    if (a[7:0] == 8'hF0) return IRQ_ON ? 32'(m_stat) : 32'h0;
    if (a[7:0] == 8'hF4) return IRQ_ON ? 32'(m_ien) : 32'h0;
    if (a[1:0] != 2'b00 || ch >= NUM_CH) return 32'h0;
    case (a[3:2])
      2'd0:    return 32'(m_sp[ch]);
      2'd1:    return 32'(m_sc[ch]);
      2'd2:    return 32'(m_ctrl[ch]);
      default: return 32'(m_cnt(ch));
    endcase
  endfunction

  task automatic m_update(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [NUM_CH-1:0] bnd;
    logic [NUM_CH-1:0] new_pwm;
    logic              new_irq;
    int                en, pol, ctr, per;
    bnd = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      en  = m_ctrl[n] & 1;
      pol = (m_ctrl[n] >> 1) & 1;
      ctr = (m_ctrl[n] >> 2) & 1;
      if (en == 1 && m_ap[n] != 0) new_pwm[n] = ((m_cnt(n) < m_ac[n]) ? 1'b1 : 1'b0) ^ pol[0];
      else                         new_pwm[n] = pol[0];
      if (en == 0) begin
        m_ap[n] = m_sp[n]; m_ac[n] = m_sc[n]; m_k[n] = 0;
      end else if (m_ap[n] == 0) begin
        m_k[n] = 0;
      end else begin
        per = (ctr == 1) ? 2 * m_ap[n] : m_ap[n];
        if (m_k[n] == per - 1) begin
          bnd[n] = 1'b1; m_k[n] = 0; m_ap[n] = m_sp[n]; m_ac[n] = m_sc[n];
        end else begin
          m_k[n]++;
        end
      end
      if (wr && int'(a[7:0]) == n * 16 + 8 && int'(d[2]) != ctr) m_k[n] = 0;
    end
    new_irq = |(m_stat & m_ien);
    if (wr) begin
      if (a[7:0] == 8'hF0) m_stat = m_stat & ~d[NUM_CH-1:0];
      else if (a[7:0] == 8'hF4) m_ien = d[NUM_CH-1:0];
      else if (a[1:0] == 2'b00 && int'(a[7:4]) < NUM_CH) begin
        case (a[3:2])
          2'd0:    m_sp[a[7:4]]   = int'(d) & MASK;
          2'd1:    m_sc[a[7:4]]   = int'(d) & MASK;
          2'd2:    m_ctrl[a[7:4]] = int'(d) & 7;
          default: ;
        endcase
      end
    end
    m_stat = m_stat | bnd;
    m_pwm  = new_pwm;
    m_irq  = IRQ_ON ? new_irq : 1'b0;
  endtask

  // driver tasks: one bus cycle, checking outputs mid-cycle
  task automatic step(input logic s, input logic e, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = s; pen = e; pwrite = w; paddr = a; pwdata = d;
    #1;
    exp_q.push_back((s & e & ~w) ? m_read(a) : 32'h0);
    check("prdata", prdata, exp_q.pop_front());
    check("pwm_out", 32'(pwm), 32'(m_pwm));
    check("pwm_irq", 32'(irq), 32'(m_irq));
    @(posedge clk);
    m_update(s & e & w, a, d);
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, 1'b1, a, d);
    step(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic apb_read(input logic [31:0] a);
    step(1'b1, 1'b0, 1'b0, a, 32'h0);
    step(1'b1, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", 32'(pwm), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_prdata", prdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // all registers read 0 after reset (includes unmapped space)
    for (int a = 0; a < 256; a += 4) apb_read(32'(a));

    // ch0 edge mode 3/10, reading CNT as it runs
    apb_write(32'h00, 32'd10);
    apb_write(32'h04, 32'd3);
    apb_write(32'h08, 32'd1);
    for (int i = 0; i < 12; i++) apb_read(32'h0C);

    // ch1 duty change mid-period must wait for the boundary
    apb_write(32'h10, 32'd8);
    apb_write(32'h14, 32'd2);
    apb_write(32'h18, 32'd1);
    idle(11);
    apb_write(32'h14, 32'd6);
    idle(20);

    // ch2 center mode, inverted polarity
    apb_write(32'h20, 32'd4);
    apb_write(32'h24, 32'd2);
    apb_write(32'h28, 32'd7);
    for (int i = 0; i < 10; i++) apb_read(32'h2C);
    apb_write(32'h28, 32'd3);   // drop CENTER mid-period: restart
    idle(9);
    apb_write(32'h28, 32'd7);
    idle(5);

    // ch3 boundary cases
    apb_write(32'h30, 32'd5);
    apb_write(32'h34, 32'd0);
    apb_write(32'h38, 32'd1);
    idle(12);
    apb_write(32'h34, 32'd5);
    idle(14);
    apb_write(32'h30, 32'd0);
    idle(10);
    apb_write(32'h30, 32'd7);
    idle(6);
    apb_write(32'h38, 32'd0);
    apb_write(32'h38, 32'd1);
    idle(5);
    apb_write(32'h38, 32'd0);
    apb_read(32'h3C);
    apb_write(32'h38, 32'h0001_0005);  // upper bits ignored: EN+CENTER
    idle(8);

    // interrupt path
    apb_write(32'hF4, 32'h1);
    apb_write(32'h00, 32'd5);
    idle(14);
    apb_read(32'hF0);
    apb_write(32'hF0, 32'h1);
    apb_read(32'hF0);
    idle(6);
    apb_write(32'hF0, 32'hF);
    apb_read(32'hF0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int          kind;
      int          ch;
      logic [31:0] hi;
      logic [31:0] ahi;
      kind = $urandom_range(0, 9);
      ch   = $urandom_range(0, NUM_CH);          // NUM_CH itself is unmapped
      hi   = $urandom & 32'hFFFF_0000;
      ahi  = $urandom & 32'hFFFF_FF00;
      case (kind)
        0, 1: apb_write(ahi | 32'(ch * 16),     hi | 32'($urandom_range(0, 9)));
        2, 3: apb_write(ahi | 32'(ch * 16 + 4), hi | 32'($urandom_range(0, 10)));
        4:    apb_write(ahi | 32'(ch * 16 + 8), hi | 32'($urandom_range(0, 7)));
        5, 6: apb_read(ahi | 32'(ch * 16 + $urandom_range(0, 15)));
        7:    apb_write(ahi | (($urandom_range(0, 1) == 1) ? 32'hF0 : 32'hF4), 32'($urandom_range(0, 15)));
        8:    apb_read(ahi | (($urandom_range(0, 1) == 1) ? 32'hF0 : 32'hF4));
        default: idle($urandom_range(1, 8));
      endcase
    end

    // asynchronous reset in the middle of a period
    apb_write(32'h28, 32'd7);
    apb_write(32'h08, 32'd1);
    apb_write(32'hF4, 32'hF);
    idle(7);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pwm", 32'(pwm), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apb_read(32'h28);
    apb_read(32'h0C);
    apb_read(32'hF4);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
